key_scan: RTL and testbench

Matrix-keypad front end for the calculator. It scans a 4x4 active-low key matrix, synchronizes and debounces the row returns, and encodes each accepted press into a 4-bit key code. Each press is emitted as a single `key_value`/`flag` event, which is the producer side of the interface that the calculator input controller consumes. It runs on the same 1 kHz clock as the input controller, so no clock-domain crossing exists between the two.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 22 ++
 rtl/key_scan.sv | 135 +++++++++++++
 tb/tb_key_scan.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad path: key codes, scanner states,
// parameter defaults and small helpers for decoding active-low row returns.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'ha;
  localparam logic [3:0] KEY_SUB = 4'hb;
  localparam logic [3:0] KEY_MUL = 4'hc;
  localparam logic [3:0] KEY_DIV = 4'hd;
  localparam logic [3:0] KEY_EQ  = 4'he;
  localparam logic [3:0] KEY_CLR = 4'hf;

  localparam int COL_DWELL_DEF = 3;
  localparam int DEB_CNT_DEF   = 10;
  localparam int FLAG_LEN_DEF  = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } scan_state_e;

  // True when exactly one of the four active-low rows is pulled low.
  function automatic logic is_one_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row returns; idles at
// all-ones so a reset looks like "no key pressed".
module sync_2ff (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      meta <= 4'hf;
      q    <= 4'hf;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: rotates one low column, debounces a single-row return,
// and emits one key_value/flag event per accepted press.
module key_scan
  import calc_pkg::*;
#(
  parameter int COL_DWELL = COL_DWELL_DEF,
  parameter int DEB_CNT   = DEB_CNT_DEF,
  parameter int FLAG_LEN  = FLAG_LEN_DEF
) (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       flag
);

  localparam int CNT_MAX = (COL_DWELL > DEB_CNT) ?
                           ((COL_DWELL > FLAG_LEN) ? COL_DWELL : FLAG_LEN) :
                           ((DEB_CNT > FLAG_LEN) ? DEB_CNT : FLAG_LEN);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(COL_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] FLAG_END   = CNT_W'(FLAG_LEN);

  scan_state_e      state, state_n;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       row_idx, row_idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       key_value_n;
  logic             flag_n;
  logic [3:0]       row_s;

  sync_2ff u_sync (
    .CLK_1K (CLK_1K),
    .RST    (RST),
    .d      (row),
    .q      (row_s)
  );

  assign col = ~(4'b0001 << col_idx);

  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cnt       <= '0;
      key_value <= 4'h0;
      flag      <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      cnt       <= cnt_n;
      key_value <= key_value_n;
      flag      <= flag_n;
    end
  end

  // One counter is shared: dwell in SCAN, matches in DEBOUNCE, pulse length in
  // EMIT and clean-release cycles in WAIT_REL. It is cleared on every transition.
  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    row_idx_n   = row_idx;
    cnt_n       = cnt;
    key_value_n = key_value;
    flag_n      = 1'b0;

    case (state)
      SCAN: begin
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (is_one_low(row_s)) begin
            row_idx_n = low_index(row_s);
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s == ~(4'b0001 << row_idx)) begin
          if (cnt == DEB_LAST) begin
            cnt_n       = '0;
            key_value_n = {row_idx, col_idx};
            state_n     = EMIT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n     = '0;
          col_idx_n = col_idx + 2'd1;
          state_n   = SCAN;
        end
      end

      // key_value was loaded on entry, so flag rises one cycle behind it.
      EMIT: begin
        if (cnt == FLAG_END) begin
          cnt_n   = '0;
          state_n = WAIT_REL;
        end else begin
          cnt_n  = cnt + 1'b1;
          flag_n = 1'b1;
        end
      end

      WAIT_REL: begin
        if (row_s == 4'hf) begin
          if (cnt == DEB_LAST) begin
            cnt_n     = '0;
            col_idx_n = col_idx + 2'd1;
            state_n   = SCAN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
      end

      default: begin
        cnt_n   = '0;
        state_n = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: a keypad matrix model drives the rows, a
// monitor collects flag events, and tests compare them with expected key codes.
module tb_key_scan;

  localparam int COL_DWELL = 3;
  localparam int DEB_CNT   = 10;
  localparam int FLAG_LEN  = 4;
  localparam int LAT_MAX   = 4 * COL_DWELL + DEB_CNT + 3;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] exp_code;
  } vec_t;

  logic       CLK_1K = 1'b0;
  logic       RST;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       flag;

  logic [15:0] keys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] ev_code[$];
  int         ev_cyc[$];
  int         ev_len[$];

  logic       prev_flag = 1'b0;
  logic       in_pulse  = 1'b0;
  int         plen      = 0;
  int         since_fall = 1000;
  logic [3:0] prev_kv   = 4'h0;

  key_scan #(
    .COL_DWELL (COL_DWELL),
    .DEB_CNT   (DEB_CNT),
    .FLAG_LEN  (FLAG_LEN)
  ) dut (
    .CLK_1K    (CLK_1K),
    .RST       (RST),
    .row       (row),
    .col       (col),
    .key_value (key_value),
    .flag      (flag)
  );

  always #5 CLK_1K = ~CLK_1K;

  always @(posedge CLK_1K) cyc = cyc + 1;

  // A row reads low whenever a pressed key in it sits on the driven column.
  always_comb begin
    row = 4'hf;
    for (int r = 0; r < 4; r++)
      row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  function automatic int isOneCold(input logic [3:0] v);
    return int'((v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111));
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic down);
    keys[r*4 + c] = down;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK_1K);
  endtask

  task automatic clearEvents();
    ev_code.delete();
    ev_cyc.delete();
    ev_len.delete();
  endtask

  task automatic waitEvents(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (ev_code.size() < n && i < budget) begin
      @(negedge CLK_1K);
      i++;
    end
    checkOutput(name, ev_code.size(), n);
  endtask

  // Event monitor: records each flag rise, its pulse length, and checks that
  // key_value is steady while flag is high and for DEB_CNT cycles after it falls.
  always @(negedge CLK_1K) begin
    if (RST !== 1'b1) begin
      prev_flag  = 1'b0;
      in_pulse   = 1'b0;
      plen       = 0;
      since_fall = 1000;
      prev_kv    = key_value;
    end else begin
      if (flag && !prev_flag) begin
        ev_code.push_back(key_value);
        ev_cyc.push_back(cyc);
        in_pulse = 1'b1;
        plen     = 0;
      end
      if (flag) plen++;
      if (!flag && prev_flag && in_pulse) begin
        ev_len.push_back(plen);
        in_pulse   = 1'b0;
        since_fall = 0;
      end else if (!flag && since_fall < 1000) begin
        since_fall++;
      end
      if (flag || since_fall < DEB_CNT)
        checkOutput("key_value stable", key_value, prev_kv);
      checkOutput("col one low", isOneCold(col), 1);
      prev_flag = flag;
      prev_kv   = key_value;
    end
  end

  initial begin
    vec_t       vecs[7];
    int         t0, t_set, t_rel, n_hold, changes, r, c, nb;
    logic [3:0] prev_col;
    int         exp_q[$];
    int         fixed_seq[4];

    vecs[0] = '{r: 1, c: 2, exp_code: 4'h6};
    vecs[1] = '{r: 3, c: 2, exp_code: 4'he};
    vecs[2] = '{r: 2, c: 1, exp_code: 4'h9};
    vecs[3] = '{r: 0, c: 0, exp_code: 4'h0};
    vecs[4] = '{r: 3, c: 3, exp_code: 4'hf};
    vecs[5] = '{r: 2, c: 2, exp_code: 4'ha};
    vecs[6] = '{r: 0, c: 3, exp_code: 4'h3};

    keys = 16'h0;
    RST  = 1'b0;
    #1;
    checkOutput("reset col", col, 4'b1110);
    checkOutput("reset key_value", key_value, 4'h0);
    checkOutput("reset flag", flag, 0);
    repeat (3) @(posedge CLK_1K);
    #2 RST = 1'b1;
    waitCycles(5);

    // Clean single presses from the table.
    for (int i = 0; i < 7; i++) begin
      clearEvents();
      t0 = cyc;
      applyStimulus(vecs[i].r, vecs[i].c, 1'b1);
      waitEvents(1, LAT_MAX + 10, "press event seen");
      checkOutput("press code", (ev_code.size() > 0) ? int'(ev_code[0]) : -1, vecs[i].exp_code);
      checkOutput("press latency within bound",
                  (ev_cyc.size() > 0) ? int'(ev_cyc[0] - t0 <= LAT_MAX) : 0, 1);
      waitCycles(20);
      applyStimulus(vecs[i].r, vecs[i].c, 1'b0);
      waitCycles(40);
      checkOutput("press single event", ev_code.size(), 1);
      checkOutput("press pulse length", (ev_len.size() > 0) ? ev_len[0] : -1, FLAG_LEN);
    end

    // Bouncing press on row3/col2 before it settles.
    clearEvents();
    for (int b = 0; b < 3; b++) begin
      applyStimulus(3, 2, 1'b1);
      waitCycles(2);
      applyStimulus(3, 2, 1'b0);
      waitCycles(2);
    end
    applyStimulus(3, 2, 1'b1);
    t_set = cyc;
    waitCycles(60);
    applyStimulus(3, 2, 1'b0);
    waitCycles(40);
    checkOutput("bounce single event", ev_code.size(), 1);
    checkOutput("bounce code", (ev_code.size() > 0) ? int'(ev_code[0]) : -1, 4'he);
    checkOutput("bounce rise after settle",
                (ev_cyc.size() > 0) ? int'(ev_cyc[0] - t_set >= DEB_CNT) : 0, 1);

    // Two rows in the same column: rejected, scan keeps rotating.
    clearEvents();
    applyStimulus(0, 1, 1'b1);
    applyStimulus(2, 1, 1'b1);
    prev_col = col;
    changes  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK_1K);
      if (col != prev_col) begin
        checkOutput("col rotate", col, {prev_col[2:0], prev_col[3]});
        changes++;
      end
      prev_col = col;
    end
    checkOutput("multi-key scan keeps moving", int'(changes >= 16), 1);
    checkOutput("multi-key no event", ev_code.size(), 0);
    applyStimulus(0, 1, 1'b0);
    applyStimulus(2, 1, 1'b0);
    waitCycles(20);

    // Long hold of 9 with a bouncy release, then 'a' pressed straight after.
    clearEvents();
    applyStimulus(2, 1, 1'b1);
    waitCycles(500);
    n_hold = ev_code.size();
    checkOutput("long hold single event", n_hold, 1);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(2, 1, 1'b0);
      waitCycles(2);
      applyStimulus(2, 1, 1'b1);
      waitCycles(2);
    end
    applyStimulus(2, 1, 1'b0);
    applyStimulus(2, 2, 1'b1);
    t_rel = cyc;
    waitEvents(2, 100, "next key after release");
    checkOutput("long hold code", (ev_code.size() > 0) ? int'(ev_code[0]) : -1, 4'h9);
    checkOutput("next key code", (ev_code.size() > 1) ? int'(ev_code[1]) : -1, 4'ha);
    checkOutput("next key waits for clean release",
                (ev_cyc.size() > 1) ? int'(ev_cyc[1] - t_rel >= DEB_CNT) : 0, 1);
    waitCycles(20);
    applyStimulus(2, 2, 1'b0);
    waitCycles(40);
    checkOutput("long hold total events", ev_code.size(), 2);

    // Reset during the second flag-high cycle; the held key is seen afresh.
    clearEvents();
    applyStimulus(1, 1, 1'b1);
    waitEvents(1, LAT_MAX + 10, "pre-reset event");
    @(posedge CLK_1K);
    #2 RST = 1'b0;
    #1;
    checkOutput("async reset flag", flag, 0);
    checkOutput("async reset key_value", key_value, 4'h0);
    checkOutput("async reset col", col, 4'b1110);
    @(posedge CLK_1K);
    @(posedge CLK_1K);
    #2 RST = 1'b1;
    waitEvents(2, LAT_MAX + 15, "re-detect after reset");
    checkOutput("re-detect code", (ev_code.size() > 1) ? int'(ev_code[1]) : -1, 4'h5);
    waitCycles(20);
    applyStimulus(1, 1, 1'b0);
    waitCycles(40);
    checkOutput("cut pulse not resumed", ev_len.size(), 1);
    checkOutput("fresh pulse length", (ev_len.size() > 0) ? ev_len[0] : -1, FLAG_LEN);

    // Back-to-back 1, a, 2, e followed by random presses with bounce.
    clearEvents();
    fixed_seq = '{1, 10, 2, 14};
    for (int k = 0; k < 24; k++) begin
      if (k < 4) begin
        r  = fixed_seq[k] / 4;
        c  = fixed_seq[k] % 4;
        nb = 0;
      end else begin
        r  = int'($urandom_range(0, 3));
        c  = int'($urandom_range(0, 3));
        nb = int'($urandom_range(0, 3));
      end
      exp_q.push_back(r * 4 + c);
      for (int b = 0; b < nb; b++) begin
        applyStimulus(r, c, 1'b1);
        waitCycles(int'($urandom_range(1, 2)));
        applyStimulus(r, c, 1'b0);
        waitCycles(int'($urandom_range(1, 2)));
      end
      applyStimulus(r, c, 1'b1);
      waitCycles(int'($urandom_range(45, 80)));
      applyStimulus(r, c, 1'b0);
      waitCycles(int'($urandom_range(16, 30)));
    end
    waitCycles(40);
    checkOutput("sequence event count", ev_code.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      checkOutput("sequence code", (k < ev_code.size()) ? int'(ev_code[k]) : -1, exp_q[k]);
      checkOutput("sequence pulse length", (k < ev_len.size()) ? ev_len[k] : -1, FLAG_LEN);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
